// File: rtl/sobel_ctrl_if.sv
// Video timing bundle for the Sobel sequencing controller:
// raw dv/hs/vs in, control strobes, indices and re-aligned timing out.
interface sobel_ctrl_if #(
    parameter int CNT_W = 12
);
    logic             dv_i;
    logic             hs_i;
    logic             vs_i;
    logic             line_end_o;
    logic             win_valid_o;
    logic             border_o;
    logic [CNT_W-1:0] x_o;
    logic [CNT_W-1:0] y_o;
    logic [CNT_W-1:0] width_o;
    logic             err_o;
    logic [1:0]       state_o;
    logic             dv_o;
    logic             hs_o;
    logic             vs_o;

    modport master (
        output dv_i, hs_i, vs_i,
        input  line_end_o, win_valid_o, border_o, x_o, y_o, width_o,
               err_o, state_o, dv_o, hs_o, vs_o
    );

    modport slave (
        input  dv_i, hs_i, vs_i,
        output line_end_o, win_valid_o, border_o, x_o, y_o, width_o,
               err_o, state_o, dv_o, hs_o, vs_o
    );
endinterface

// File: rtl/sobel_ctrl.sv
// Sobel path sequencer: tracks column/row from dv/vs, strobes line ends to
// the line buffer, decides when a full 3x3 window exists and re-times
// dv/hs/vs to the datapath latency.
//
// state | meaning
// IDLE  | no frame start seen since reset; dv ignored
// PRIME | lines 0 and 1 of a frame are filling the line buffer
// RUN   | three lines available; window valid from column 2 onward
module sobel_ctrl #(
    parameter int CNT_W   = 12,
    parameter int LATENCY = 4
) (
    input logic          clk,
    input logic          rst,
    sobel_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX = '1;
    localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dv_q;
    logic             r_vs_q;
    logic             w_fs;
    logic             w_le;
    logic             w_active;
    logic             w_line_end;
    logic             w_win;
    logic             w_border;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] r_x_o;
    logic [CNT_W-1:0] r_y_o;
    logic [CNT_W-1:0] r_width;
    logic             r_err;
    logic             r_line_end;
    logic             r_win;
    logic             r_border;
    logic [2:0]       r_dly [LATENCY];

    assign w_fs     = bus.vs_i & ~r_vs_q;
    assign w_le     = ~bus.dv_i & r_dv_q;
    assign w_active = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: frame start restarts priming; second line end enters RUN
    always_comb begin
        w_state_nxt = r_state;
        if (w_fs) begin
            w_state_nxt = S_PRIME;
        end else begin
            case (r_state)
                S_PRIME: if (w_le && (r_y != '0)) w_state_nxt = S_RUN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Per-pixel strobes; a frame-start pixel never completes a window
    always_comb begin
        w_line_end = w_le & w_active;
        w_win      = (r_state == S_RUN) & bus.dv_i & ~w_fs & (r_x >= C_TWO);
        w_border   = (r_state == S_RUN) & bus.dv_i & ~w_fs & (r_x <  C_TWO);
    end

    // Counters, width measurement, error flag and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dv_q     <= 1'b0;
            r_vs_q     <= 1'b0;
            r_line_end <= 1'b0;
            r_win      <= 1'b0;
            r_border   <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_x_o      <= '0;
            r_y_o      <= '0;
            r_width    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_dv_q     <= bus.dv_i;
            r_vs_q     <= bus.vs_i;
            r_line_end <= w_line_end;
            r_win      <= w_win;
            r_border   <= w_border;
            if (w_fs) begin
                r_x   <= '0;
                r_y   <= '0;
                r_err <= 1'b0;
                if (bus.dv_i) begin
                    r_x_o <= '0;
                    r_y_o <= '0;
                end
            end else if (w_active) begin
                if (bus.dv_i) begin
                    r_x_o <= r_x;
                    r_y_o <= r_y;
                    if (r_x != C_MAX) r_x <= r_x + 1'b1;
                end
                if (w_le) begin
                    r_x <= '0;
                    if (r_y != C_MAX) r_y <= r_y + 1'b1;
                    if (r_y == '0)            r_width <= r_x;
                    else if (r_x != r_width)  r_err   <= 1'b1;
                end
            end
        end
    end

    // Timing re-alignment, free-running regardless of controller state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_dly[i] <= 3'b000;
        end else begin
            r_dly[0] <= {bus.dv_i, bus.hs_i, bus.vs_i};
            for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign bus.line_end_o  = r_line_end;
    assign bus.win_valid_o = r_win;
    assign bus.border_o    = r_border;
    assign bus.x_o         = r_x_o;
    assign bus.y_o         = r_y_o;
    assign bus.width_o     = r_width;
    assign bus.err_o       = r_err;
    assign bus.state_o     = r_state;
    assign bus.dv_o        = r_dly[LATENCY-1][2];
    assign bus.hs_o        = r_dly[LATENCY-1][1];
    assign bus.vs_o        = r_dly[LATENCY-1][0];
endmodule

// File: tb/tb_sobel_ctrl.sv
// Bench for sobel_ctrl: three instances (LATENCY 4, 1, 32) share stimulus.
// A frame-level reference model predicts every cycle's outputs into a
// queue; a negedge monitor pops and compares.
module tb_sobel_ctrl;
    localparam int W    = 12;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_ctrl_if #(.CNT_W(W)) bus4 ();
    sobel_ctrl_if #(.CNT_W(W)) bus1 ();
    sobel_ctrl_if #(.CNT_W(W)) bus32 ();

    sobel_ctrl #(.CNT_W(W), .LATENCY(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    sobel_ctrl #(.CNT_W(W), .LATENCY(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    sobel_ctrl #(.CNT_W(W), .LATENCY(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    typedef struct packed {
        logic         le;
        logic         win;
        logic         border;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] width;
        logic         err;
        logic [1:0]   st;
        logic [2:0]   d4;
        logic [2:0]   d1;
        logic [2:0]   d32;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    // Reference model: frame-level bookkeeping
    bit         m_in_frame;
    int         m_pix;
    int         m_lines;
    int         m_width;
    bit         m_err;
    int         m_xo;
    int         m_yo;
    bit         m_dv_prev;
    bit         m_vs_prev;
    logic [2:0] m_hist[$];

    function automatic logic [2:0] delayed(input int lat);
        if (m_hist.size() >= lat) return m_hist[lat-1];
        return 3'b000;
    endfunction

    task automatic model_step(input logic r, input logic d, input logic h, input logic v);
        exp_t e;
        bit   fs, le, full;
        e = '0;
        if (r) begin
            m_in_frame = 0; m_pix = 0; m_lines = 0; m_width = 0; m_err = 0;
            m_xo = 0; m_yo = 0; m_dv_prev = 0; m_vs_prev = 0;
            m_hist.delete();
            sb_q.push_back(e);
            return;
        end
        fs   = v && !m_vs_prev;
        le   = !d && m_dv_prev;
        full = m_in_frame && (m_lines >= 2);
        e.le     = le && m_in_frame;
        e.win    = full && d && !fs && (m_pix >= 2);
        e.border = full && d && !fs && (m_pix < 2);
        if (fs) begin
            m_in_frame = 1; m_pix = 0; m_lines = 0; m_err = 0;
            if (d) begin m_xo = 0; m_yo = 0; end
        end else if (m_in_frame) begin
            if (d) begin
                m_xo  = m_pix;
                m_yo  = m_lines;
                m_pix = (m_pix < MAXV) ? m_pix + 1 : MAXV;
            end
            if (le) begin
                if (m_lines == 0)          m_width = m_pix;
                else if (m_pix != m_width) m_err   = 1;
                m_lines = (m_lines < MAXV) ? m_lines + 1 : MAXV;
                m_pix   = 0;
            end
        end
        e.x     = W'(m_xo);
        e.y     = W'(m_yo);
        e.width = W'(m_width);
        e.err   = m_err;
        e.st    = !m_in_frame ? 2'd0 : ((m_lines >= 2) ? 2'd2 : 2'd1);
        m_dv_prev = d;
        m_vs_prev = v;
        m_hist.push_front({d, h, v});
        if (m_hist.size() > 40) void'(m_hist.pop_back());
        e.d4  = delayed(4);
        e.d1  = delayed(1);
        e.d32 = delayed(32);
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle
    always @(negedge clk) begin
        exp_t e;
        logic [41:0] act_ctrl;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act_ctrl = {bus4.line_end_o, bus4.win_valid_o, bus4.border_o, bus4.x_o,
                        bus4.y_o, bus4.width_o, bus4.err_o, bus4.state_o};
            chk("ctrl{le,win,bord,x,y,width,err,state}", 64'(act_ctrl),
                64'({e.le, e.win, e.border, e.x, e.y, e.width, e.err, e.st}));
            chk("delay4{dv,hs,vs}",  64'({bus4.dv_o,  bus4.hs_o,  bus4.vs_o}),  64'(e.d4));
            chk("delay1{dv,hs,vs}",  64'({bus1.dv_o,  bus1.hs_o,  bus1.vs_o}),  64'(e.d1));
            chk("delay32{dv,hs,vs}", 64'({bus32.dv_o, bus32.hs_o, bus32.vs_o}), 64'(e.d32));
        end
    end

    task automatic tick(input logic r, input logic d, input logic h, input logic v);
        rst = r;
        bus4.dv_i  = d; bus4.hs_i  = h; bus4.vs_i  = v;
        bus1.dv_i  = d; bus1.hs_i  = h; bus1.vs_i  = v;
        bus32.dv_i = d; bus32.hs_i = h; bus32.vs_i = v;
        @(posedge clk);
        model_step(r, d, h, v);
        #1;
    endtask

    task automatic line(input int n, input int blank);
        for (int i = 0; i < n; i++)     tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < blank; i++) tick(1'b0, 1'b0, (i < 2), 1'b0);
    endtask

    task automatic fs_pulse();
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus4.dv_i = 0;  bus4.hs_i = 0;  bus4.vs_i = 0;
        bus1.dv_i = 0;  bus1.hs_i = 0;  bus1.vs_i = 0;
        bus32.dv_i = 0; bus32.hs_i = 0; bus32.vs_i = 0;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);

        // dv activity with no frame start: only delay lines respond
        repeat (16) line(8, 4);

        // nominal frame: 4 lines of 8
        fs_pulse();
        repeat (4) line(8, 4);

        // line 2 short: err from that line end until next frame start
        fs_pulse();
        line(8, 4); line(8, 4); line(7, 4); line(8, 4);
        fs_pulse();
        repeat (3) line(8, 4);

        // frame start in the middle of line 3 at x=5
        fs_pulse();
        repeat (3) line(8, 4);
        repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        line(0, 4);
        repeat (4) line(8, 4);

        // reset during RUN, then pixels ignored until a frame start
        fs_pulse();
        repeat (3) line(8, 4);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
        line(0, 4);
        repeat (2) line(8, 4);
        fs_pulse();
        repeat (3) line(6, 3);

        // randomized frames with occasional length errors
        for (int f = 0; f < 8; f++) begin
            int w;
            w = int'($urandom_range(3, 12));
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                tick(1'b0, 1'b0, 1'($urandom), 1'b1);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            for (int l = 0; l < int'($urandom_range(2, 6)); l++) begin
                int n;
                n = w;
                if ($urandom_range(0, 5) == 0) n = w + ($urandom_range(0, 1) == 0 ? -1 : 1);
                line(n, int'($urandom_range(1, 4)));
            end
        end

        // fully random timing, rare resets
        for (int c = 0; c < 600; c++)
            tick(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0));

        repeat (40) tick(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
